muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit for the custom processor's execute stage. It sits between the register file's read ports and its write port. Operands come from the register file's two read outputs. It computes one of four M-extension-style results over `width` cycles, then writes the result back through the register file's single write port (`wenable`/`rd`/`rd_in`) with a start/busy/done handshake.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative unsigned MUL/MULHU/DIVU/REMU unit that writes its
//            result back through the register file's single write port.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int TOTAL_REG   = 32,
    parameter int ADDRESS_REG = $clog2(TOTAL_REG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [WIDTH-1:0]       opa,
    input  logic [WIDTH-1:0]       opb,
    input  logic [ADDRESS_REG-1:0] dest,
    output logic                   busy,
    output logic                   done,
    output logic                   wenable,
    output logic [ADDRESS_REG-1:0] rd,
    output logic [WIDTH-1:0]       rd_in
);

    localparam int               c_cnt_w  = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_op_mul   = 2'b00;
    localparam logic [1:0] c_op_mulhu = 2'b01;
    localparam logic [1:0] c_op_divu  = 2'b10;
    localparam logic [1:0] c_op_remu  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [1:0]             r_op;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [ADDRESS_REG-1:0] r_dest;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half holds dividend bits shifting out / quotient bits shifting in.
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_rem;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_wen;
    logic [ADDRESS_REG-1:0] r_rd;
    logic [WIDTH-1:0]       r_rd_in;

    logic [WIDTH:0]         w_mul_sum;
    logic [WIDTH:0]         w_rem_sh;
    logic                   w_ge;
    logic [WIDTH-1:0]       w_rem_sub;
    logic [WIDTH-1:0]       w_result;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_rem_sh  = {r_rem, r_acc[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    // A successful subtraction always leaves a value below the divisor, so WIDTH bits suffice.
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;

    always_comb begin
        w_result = '0;
        case (r_op)
            c_op_mul:   w_result = r_acc[WIDTH-1:0];
            c_op_mulhu: w_result = r_acc[2*WIDTH-1:WIDTH];
            c_op_divu:  w_result = r_acc[WIDTH-1:0];
            c_op_remu:  w_result = r_rem;
            default:    w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_dest  <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wen   <= 1'b0;
            r_rd    <= '0;
            r_rd_in <= '0;
        end else begin
            r_done <= 1'b0;
            r_wen  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The cycle presenting done still counts as busy; no acceptance there.
                    if (start && !r_done) begin
                        r_op    <= op;
                        r_a     <= opa;
                        r_b     <= opb;
                        r_dest  <= dest;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_acc   <= {{WIDTH{1'b0}}, (op[1] ? opa : opb)};
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else if (r_done) begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[1]) begin
                        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_ge};
                        r_rem            <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    if (r_cnt == c_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_wen   <= (r_dest != '0);
                    r_rd    <= r_dest;
                    r_rd_in <= w_result;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign wenable = r_wen;
    assign rd      = r_rd;
    assign rd_in   = r_rd_in;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic [4:0]  dest;
    logic        busy, done, wenable;
    logic [4:0]  rd;
    logic [31:0] rd_in;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .dest(dest), .busy(busy), .done(done), .wenable(wenable), .rd(rd), .rd_in(rd_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_assert++;
        n_fail++;
        $display("FAIL %s: timed out at t=%0t", nm, $time);
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Reference model: request timeline in edges since acceptance.
    int          edge_n    = 0;
    int          free_edge = 0;
    int          acc_edge  = 0;
    bit          pend      = 0;
    bit          model_ok  = 0;
    logic [31:0] pend_res;
    logic [4:0]  pend_dest;
    logic        exp_busy, exp_done, exp_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_rd_in;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            pend = 0; exp_busy = 0; exp_done = 0; exp_wen = 0; exp_rd = 0; exp_rd_in = 0;
            free_edge = edge_n + 1;
            model_ok  = 1;
        end else begin
            exp_done = 0;
            exp_wen  = 0;
            if (pend && edge_n == acc_edge + W + 1) begin
                exp_done = 1; exp_wen = (pend_dest != 0); exp_rd = pend_dest; exp_rd_in = pend_res;
            end
            if (pend && edge_n == acc_edge + W + 2) begin
                pend = 0; exp_busy = 0;
            end
            if (start && !pend && edge_n >= free_edge) begin
                pend = 1; acc_edge = edge_n; exp_busy = 1; free_edge = edge_n + W + 3;
                pend_res = ref_res(op, opa, opb); pend_dest = dest;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy",    32'(busy),    32'(exp_busy));
            chk("done",    32'(done),    32'(exp_done));
            chk("wenable", 32'(wenable), 32'(exp_wen));
            chk("rd",      32'(rd),      32'(exp_rd));
            chk("rd_in",   rd_in,        exp_rd_in);
        end
    end

    int wen_pulses = 0;
    always @(negedge clk) if (wenable === 1'b1) wen_pulses++;

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_now("wait_idle");
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input bit lit, input logic [31:0] expv);
        int t;
        int acc_e;
        wait_idle();
        start = 1; op = o; opa = a; opb = b; dest = d;
        @(posedge clk); #1;
        acc_e = edge_n;
        start = 0;
        op = 2'($urandom_range(0, 3)); opa = $urandom; opb = $urandom; dest = 5'($urandom_range(0, 31));
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < W + 10) begin @(negedge clk); t++; end
        if (t >= W + 10) begin
            fail_now("done_wait");
        end else if (lit) begin
            chk("lat_done", 32'(edge_n - acc_e), 32'(W + 1));
            chk("lit_rd_in", rd_in, expv);
            chk("lit_rd", 32'(rd), 32'(d));
            chk("lit_wen", 32'(wenable), 32'(d != 0));
            @(negedge clk);
            chk("lit_busy_fall", 32'(busy), 32'd0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int pulses;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 0; start = 0; op = 0; opa = 0; opb = 0; dest = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wen", 32'(wenable), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_rd_in", rd_in, 0);
        rst_n = 1;

        do_op(2'd0, 32'd7, 32'd6, 5'd3, 1, 32'd42);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 32'hFFFF_FFFE);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 32'h0000_0001);
        do_op(2'd2, 32'd100, 32'd7, 5'd8, 1, 32'd14);
        do_op(2'd3, 32'd100, 32'd7, 5'd8, 1, 32'd2);
        do_op(2'd2, 32'd5, 32'd9, 5'd1, 1, 32'd0);
        do_op(2'd3, 32'd5, 32'd9, 5'd1, 1, 32'd5);
        do_op(2'd2, 32'd123, 32'd0, 5'd31, 1, 32'hFFFF_FFFF);
        do_op(2'd3, 32'd123, 32'd0, 5'd31, 1, 32'd123);
        do_op(2'd0, 32'd3, 32'd4, 5'd0, 1, 32'd12);

        // Keep start high with changing operands for the whole request.
        wait_idle();
        start = 1; op = 2'd0; opa = 32'd1234; opb = 32'd5678; dest = 5'd9;
        @(posedge clk); #1;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && t < W + 10) begin
            op = 2'($urandom_range(0, 3)); opa = $urandom; opb = $urandom; dest = 5'($urandom_range(0, 31));
            @(negedge clk);
            t++;
        end
        if (t >= W + 10) fail_now("hammer_done");
        chk("hammer_rd_in", rd_in, 32'd7006652);
        chk("hammer_rd", 32'(rd), 32'd9);
        @(negedge clk);
        start = 0;

        // Reset in the middle of RUN.
        wait_idle();
        start = 1; op = 2'd2; opa = 32'd999; opb = 32'd3; dest = 5'd12;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(negedge clk);
        pulses = wen_pulses;
        rst_n = 0; start = 1; opa = 32'd55;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rd", 32'(rd), 0);
        chk("midrst_rd_in", rd_in, 0);
        rst_n = 1; start = 0;
        repeat (W + 6) @(negedge clk);
        chk("midrst_no_write", 32'(wen_pulses), 32'(pulses));
        do_op(2'd2, 32'd1000, 32'd10, 5'd7, 1, 32'd100);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, 5'($urandom_range(0, 31)), 0, 32'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
